s3g_int_sched: RTL

- Interrupt controller and transmit scheduler for the s3g link.
- Latches 32 interrupt sources into a pending register and applies a mask.
- Shares the single s3g_tx packet transmitter between executor command replies and unsolicited interrupt reports (cmd 0x50, seq 0xFFFF), re-sending the report periodically while any unmasked interrupt stays pending.
- Sits between s3g_executor, s3g_tx and the strobe/interrupt fabric in mojo_top.

---
 rtl/s3g_int_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/s3g_int_sched.sv
// Interrupt latch/mask plus non-preemptive scheduler sharing s3g_tx between
// executor replies (tx_sel=0) and periodic interrupt reports (tx_sel=1).
module s3g_int_sched #(
  parameter int unsigned INTS_TIMER = 15000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ints,
  input  logic        mask_wr,
  input  logic [31:0] mask_data,
  input  logic [31:0] clear_stb,
  input  logic        reply_req,
  output logic        reply_ack,
  output logic        tx_start,
  output logic        tx_sel,
  input  logic        tx_done,
  output logic [31:0] report_data,
  output logic [31:0] ints_pending,
  output logic [31:0] ints_mask
);

  localparam logic [23:0] TIMER_MAX = 24'(INTS_TIMER - 1);

  typedef enum logic [1:0] {IDLE, REPLY, REPORT} state_t;

  state_t      state;
  logic [31:0] ints_prev;
  logic [31:0] reported;
  logic [23:0] timer;
  logic [31:0] rise;
  logic [31:0] active;
  logic        new_req;
  logic        timer_req;
  logic        take_reply;
  logic        take_report;

  assign rise      = ints & ~ints_prev;
  assign active    = ints_pending & ints_mask;
  assign new_req   = |(active & ~reported);
  assign timer_req = (timer == TIMER_MAX);

  // reply_req is a level held until reply_ack; in the ack cycle the executor
  // has not yet dropped it, so it must not start a second reply.
  assign take_reply  = (state == IDLE) && reply_req && !reply_ack;
  assign take_report = (state == IDLE) && !take_reply && (new_req || timer_req)
                       && (active != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ints_prev    <= '0;
      ints_pending <= '0;
      ints_mask    <= '1;
      reported     <= '0;
      timer        <= '0;
    end else begin
      ints_prev    <= ints;
      ints_pending <= (ints_pending & ~clear_stb) | rise;
      if (mask_wr) ints_mask <= mask_data;
      reported     <= (reported & active) | (take_report ? active : 32'h0);
      // Timer freezes while a report is on the wire and saturates at TIMER_MAX.
      if (active == '0) begin
        timer <= '0;
      end else if (state == REPORT) begin
        if (tx_done) timer <= '0;
      end else if (!timer_req) begin
        timer <= timer + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_sel      <= 1'b0;
      reply_ack   <= 1'b0;
      report_data <= '0;
    end else begin
      tx_start  <= 1'b0;
      reply_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (take_reply) begin
            tx_start <= 1'b1;
            tx_sel   <= 1'b0;
            state    <= REPLY;
          end else if (take_report) begin
            tx_start    <= 1'b1;
            tx_sel      <= 1'b1;
            report_data <= active;
            state       <= REPORT;
          end
        end
        REPLY: begin
          if (tx_done) begin
            reply_ack <= 1'b1;
            state     <= IDLE;
          end
        end
        REPORT: begin
          if (tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
